// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store controller in front of a byte-addressed,
// word-wide data memory. One request in flight at a time. Every memory
// access is word aligned; SB/SH become read-modify-write. Loads are
// lane-selected and sign/zero extended. Illegal or misaligned requests
// complete with an error response and never touch memory.
module lsu_ctrl #(
  parameter int noal = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [noal-1:0] req_addr,
  input  logic [31:0]     req_wdata,
  output logic            resp_valid,
  output logic [31:0]     resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [noal-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t state;
  state_t state_d;

  // Request fields held for the life of the operation.
  logic        we_q;
  logic        we_d;
  logic [2:0]  funct3_q;
  logic [2:0]  funct3_d;
  logic [1:0]  lane_q;
  logic [1:0]  lane_d;
  logic [31:0] wdata_q;
  logic [31:0] wdata_d;

  // Next values of the registered outputs.
  logic            resp_valid_d;
  logic [31:0]     resp_rdata_d;
  logic            resp_err_d;
  logic            mem_read_d;
  logic            mem_write_d;
  logic [noal-1:0] mem_addr_d;
  logic [31:0]     mem_wdata_d;

  // True when the request cannot be performed: unknown width code, a store
  // using an unsigned-load code, or an access not naturally aligned.
  function automatic logic access_error(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] lane);
    logic err;
    case (f3)
      F3_B:         err = 1'b0;
      F3_H:         err = lane[0];
      F3_W:         err = (lane != 2'b00);
      F3_BU:        err = we;
      F3_HU:        err = we | lane[0];
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

  // Pick the addressed byte/half out of the memory word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b_sel;
    logic [15:0] h_sel;
    logic [31:0] res;
    case (lane)
      2'd0:    b_sel = word[7:0];
      2'd1:    b_sel = word[15:8];
      2'd2:    b_sel = word[23:16];
      default: b_sel = word[31:24];
    endcase
    h_sel = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res = {{24{b_sel[7]}}, b_sel};
      F3_BU:   res = {24'h0, b_sel};
      F3_H:    res = {{16{h_sel[15]}}, h_sel};
      F3_HU:   res = {16'h0, h_sel};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the store byte/half onto the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word,
                                              input logic [31:0] wdata);
    logic [31:0] res;
    res = word;
    if (f3 == F3_B) begin
      case (lane)
        2'd0:    res[7:0]   = wdata[7:0];
        2'd1:    res[15:8]  = wdata[7:0];
        2'd2:    res[23:16] = wdata[7:0];
        default: res[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      res[31:16] = wdata[15:0];
    end else begin
      res[15:0] = wdata[15:0];
    end
    return res;
  endfunction

  // Only IDLE takes new work, so a request is accepted when it is valid in IDLE.
  assign req_ready = (state == IDLE);

  // Next-state and next-output decode for the whole operation sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d      = state;
    we_d         = we_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;

    case (state)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          lane_d     = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = {req_addr[noal-1:2], 2'b00};
          if (access_error(req_we, req_funct3, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && (req_funct3 == F3_W)) begin
            // Full-word store needs no read-back.
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            // Loads, and the read half of SB/SH.
            state_d    = READ;
            mem_read_d = 1'b1;
          end
        end
      end

      READ: begin
        if (!we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extend(funct3_q, lane_q, mem_rdata);
        end else begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_wdata_d = store_merge(funct3_q, lane_q, mem_rdata, wdata_q);
        end
      end

      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Captured request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
    end else begin
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// requests compared against a byte-level reference memory model.
module tb_lsu_ctrl;

  localparam int NOAL = 8;
  localparam int NBYTES = 1 << NOAL;
  localparam int NWORDS = NBYTES / 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [2:0]      req_funct3 = 3'b000;
  logic [NOAL-1:0] req_addr = '0;
  logic [31:0]     req_wdata = 32'h0;
  logic            resp_valid;
  logic [31:0]     resp_rdata;
  logic            resp_err;
  logic            mem_read;
  logic            mem_write;
  logic [NOAL-1:0] mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  lsu_ctrl #(.noal(NOAL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory the DUT talks to: word i starts as i+1.
  logic [31:0] env_mem [NWORDS];
  logic        env_loaded = 1'b0;

  assign mem_rdata = env_mem[mem_addr[NOAL-1:2]];

  always @(posedge clk) begin
    if (!env_loaded) begin
      for (int i = 0; i < NWORDS; i++) env_mem[i] <= 32'(i + 1);
      env_loaded <= 1'b1;
    end else if (mem_write) begin
      env_mem[mem_addr[NOAL-1:2]] <= mem_wdata;
    end
  end

  // Reference model: plain byte array, same initial contents.
  logic [7:0] ref_mem [NBYTES];

  function automatic logic [31:0] ref_word(input int base);
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Issue one request, watch five cycles after acceptance, and compare the
  // observed strobes/response with what the reference model predicts.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [NOAL-1:0] addr, input logic [31:0] wdata);
    int a, base, nbytes, lat, rd_exp, wr_exp, w;
    logic err_exp;
    logic [31:0] rdata_exp, wword_exp, val;
    int rd_cnt, wr_cnt, both_cnt, resp_cnt, resp_k, idle_bad;
    logic [31:0] got_rdata, wr_data;
    logic got_err;
    logic [NOAL-1:0] rd_addr, wr_addr;

    a = int'(addr);
    base = a - (a % 4);
    nbytes = 1 << f3[1:0];
    err_exp = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
              || (we && f3[2])
              || (nbytes == 2 && (a % 2) != 0)
              || (nbytes == 4 && (a % 4) != 0);
    rdata_exp = 32'h0;
    wword_exp = 32'h0;
    if (err_exp) begin
      lat = 1; rd_exp = 0; wr_exp = 0;
    end else if (!we) begin
      lat = 2; rd_exp = 1; wr_exp = 0;
      val = 32'h0;
      for (int i = 0; i < nbytes; i++) val = val | (32'(ref_mem[a+i]) << (8*i));
      if (!f3[2] && nbytes < 4 && ((val >> (8*nbytes - 1)) & 32'd1) == 32'd1)
        val = val - (32'd1 << (8*nbytes));
      rdata_exp = val;
    end else begin
      for (int i = 0; i < nbytes; i++) ref_mem[a+i] = 8'(wdata >> (8*i));
      wword_exp = ref_word(base);
      lat = (nbytes == 4) ? 2 : 3;
      rd_exp = (nbytes == 4) ? 0 : 1;
      wr_exp = 1;
    end

    w = 0;
    @(negedge clk);
    while (!req_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;

    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; resp_cnt = 0; resp_k = 0; idle_bad = 0;
    got_rdata = 32'h0; got_err = 1'b0; wr_data = 32'h0; rd_addr = '0; wr_addr = '0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) check({tag, "_busy"}, 32'(req_ready), 32'd0);
      if (mem_read && mem_write) both_cnt++;
      if (mem_read) begin rd_cnt++; rd_addr = mem_addr; end
      if (mem_write) begin wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (resp_valid) begin
        resp_cnt++;
        if (resp_k == 0) begin resp_k = k; got_rdata = resp_rdata; got_err = resp_err; end
      end else if (resp_err || resp_rdata != 32'h0) begin
        idle_bad++;
      end
      if (k < 5) @(negedge clk);
    end

    check({tag, "_lat"}, 32'(resp_k), 32'(lat));
    check({tag, "_nresp"}, 32'(resp_cnt), 32'd1);
    check({tag, "_rdata"}, got_rdata, rdata_exp);
    check({tag, "_err"}, 32'(got_err), 32'(err_exp));
    check({tag, "_nread"}, 32'(rd_cnt), 32'(rd_exp));
    check({tag, "_nwrite"}, 32'(wr_cnt), 32'(wr_exp));
    check({tag, "_overlap"}, 32'(both_cnt), 32'd0);
    check({tag, "_idle_resp"}, 32'(idle_bad), 32'd0);
    if (rd_cnt > 0) check({tag, "_raddr"}, 32'(rd_addr), 32'(base));
    if (wr_cnt > 0) begin
      check({tag, "_waddr"}, 32'(wr_addr), 32'(base));
      check({tag, "_wdata"}, wr_data, wword_exp);
    end
  endtask

  // Hold req_valid high across four word loads and check spacing/order.
  task automatic back_to_back();
    int idx, nresp, not_ready;
    int acc_c[4];
    int resp_c[4];
    logic [31:0] resp_d[4];
    idx = 0; nresp = 0; not_ready = 0;
    for (int i = 0; i < 4; i++) begin acc_c[i] = 0; resp_c[i] = 0; resp_d[i] = 32'h0; end
    req_we = 1'b0; req_funct3 = 3'b010; req_wdata = 32'h0;
    @(negedge clk);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (resp_valid && nresp < 4) begin
        resp_c[nresp] = cyc; resp_d[nresp] = resp_rdata; nresp++;
      end
      if (!req_ready) not_ready++;
      if (req_ready && idx < 4) begin
        req_valid = 1'b1;
        req_addr = NOAL'(idx * 4);
        acc_c[idx] = cyc;
        idx++;
      end else if (req_ready) begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(idx), 32'd4);
    check("b2b_nresp", 32'(nresp), 32'd4);
    check("b2b_busy_cycles", 32'(not_ready), 32'd8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_data%0d", i), resp_d[i], ref_word(4*i));
      check($sformatf("b2b_lat%0d", i), 32'(resp_c[i] - acc_c[i]), 32'd2);
      if (i > 0) check($sformatf("b2b_gap%0d", i), 32'(acc_c[i] - acc_c[i-1]), 32'd3);
    end
  endtask

  // Abort an SB during its READ cycle with reset; nothing may be written or answered.
  task automatic reset_mid_read();
    int wr_seen, resp_seen;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = NOAL'(8); req_wdata = 32'hFF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_in_read", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    wr_seen = 0; resp_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_write) wr_seen++;
      if (resp_valid) resp_seen++;
    end
    check("rst_no_write", 32'(wr_seen), 32'd0);
    check("rst_no_resp", 32'(resp_seen), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    logic [2:0] f3;
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
    for (int i = 0; i < NWORDS; i++) begin
      logic [31:0] wv;
      wv = 32'(i + 1);
      for (int j = 0; j < 4; j++) ref_mem[4*i + j] = 8'(wv >> (8*j));
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_mem_write", 32'(mem_write), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);

    back_to_back();

    // Directed scenarios.
    do_req("lw4",   1'b0, 3'b010, NOAL'(4), 32'h0);
    do_req("sb5",   1'b1, 3'b000, NOAL'(5), 32'h0000_00AB);
    do_req("lb5",   1'b0, 3'b000, NOAL'(5), 32'h0);
    do_req("lbu5",  1'b0, 3'b100, NOAL'(5), 32'h0);
    do_req("sw4",   1'b1, 3'b010, NOAL'(4), 32'h0000_0002);
    do_req("sh6",   1'b1, 3'b001, NOAL'(6), 32'h0000_8001);
    do_req("lh6",   1'b0, 3'b001, NOAL'(6), 32'h0);
    do_req("lhu6",  1'b0, 3'b101, NOAL'(6), 32'h0);
    do_req("lw4b",  1'b0, 3'b010, NOAL'(4), 32'h0);
    do_req("lw6",   1'b0, 3'b010, NOAL'(6), 32'h0);
    do_req("sh3",   1'b1, 3'b001, NOAL'(3), 32'h1234);
    do_req("f011",  1'b0, 3'b011, NOAL'(8), 32'h0);
    do_req("sbu",   1'b1, 3'b100, NOAL'(9), 32'h55);
    do_req("sb_top", 1'b1, 3'b000, NOAL'(255), 32'h0000_0080);
    do_req("lb_top", 1'b0, 3'b000, NOAL'(255), 32'h0);

    reset_mid_read();
    do_req("lw8_after_rst", 1'b0, 3'b010, NOAL'(8), 32'h0);

    // Randomized requests.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), f3,
             NOAL'($urandom_range(0, 63)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
